serial_nibble_adder: RTL
========================

# serial_nibble_adder

Multi-word add/subtract engine that processes wide operands one 4-bit nibble per clock, least-significant nibble first, through a carry-propagating nibble adder. It sits in front of the datapath consumers as the sequential stage around the 4-bit adder: it accepts full-width operands over a valid/ready handshake, rolls the carry between cycles, and presents a full-width result with carry and signed-overflow flags. It trades latency for area against a full-width combinational adder.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES bits (16 by default); legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- op_a  input  W  operand A, unsigned or two's complement.
- op_b  input  W  operand B.
- sub  input  1  0: A+B, 1: A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  A+B or A−B, modulo 2^W.
- carry_out  output  1  carry out of bit W−1; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, capture op_a, b_eff = sub ? ~op_b : op_b, carry register = sub, nibble counter = 0, a_msb = op_a[W−1], b_msb = b_eff[W−1]; go to RUN.
- RUN: each cycle add nibble[cnt] of A and b_eff plus carry register. Shift the 4-bit sum into the result register from the top, so after NIBBLES cycles nibble 0 sits in bits [3:0]. Update the carry register with the nibble carry and increment cnt. When cnt == NIBBLES−1, go to DONE.
- DONE: out_valid=1. carry_out = carry register. overflow = (a_msb == b_msb) && (result[W−1] != a_msb). result, carry_out and overflow stay stable while out_valid&&!out_ready. On out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE; in_valid is ignored there. Op inputs are sampled only on the accept edge.
- Arithmetic is modulo 2^W; no saturation.

## Timing
- Reset (async assert, any state): state=IDLE, result=0, carry_out=0, overflow=0, out_valid=0, counter=0. in_ready=1 during and after reset.
- Deassertion is synchronised externally; the first accept is possible on the first clock edge after rst_n rises.
- Latency: accept on edge 0, nibbles processed on edges 1..NIBBLES, out_valid high after edge NIBBLES.
- Back-to-back throughput: one operation per NIBBLES+2 cycles, with out_ready held 1 and in_valid held 1. DONE→IDLE takes one edge, and the next accept takes one more.
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.
- Reset asserted mid-RUN or mid-DONE aborts the operation; the partial result is never presented.
- NIBBLES=1: RUN lasts exactly one cycle.

## Structure
- Package serial_add_pkg: NIBBLE_W = 4, and the state typedef enum {IDLE, RUN, DONE}.
- Sub-module nibble_adder_cin: combinational 4-bit ripple adder with carry-in (a[3:0], b[3:0], cin → sum[3:0], cout), instantiated once.
- Top holds the FSM, counter ($clog2(NIBBLES+1) bits), operand shift registers, carry register and MSB flags.

## Test plan
Run with NIBBLES=4 unless stated.
- 0x1234 + 0x0F0F → result 0x2143, carry_out 0, overflow 0; out_valid asserts 4 cycles after accept.
- 0xFFFF + 0x0001 → 0x0000, carry_out 1, overflow 0. 0x7FFF + 0x0001 → 0x8000, carry_out 0, overflow 1.
- sub: 0x0005 − 0x0003 → 0x0002, carry_out 1. 0x0003 − 0x0005 → 0xFFFE, carry_out 0. 0x8000 − 0x0001 → 0x7FFF, overflow 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and flags unchanged, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → IDLE the next edge, then the pending request is accepted.
- Assert rst_n=0 on the 2nd RUN cycle → outputs zero immediately (asynchronous), in_ready=1. After release, 0x0001 + 0x0001 → 0x0002 with no stale carry.
- NIBBLES=1: 0xF + 0x1 → result 0x0, carry_out 1, out_valid 1 cycle after accept. Random regression of 1000 ops is checked against a reference add/sub model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial nibble add/subtract engine.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// Combinational 4-bit ripple-carry adder with carry-in; the only arithmetic
// element of the serial engine.
module nibble_adder_cin
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    cout = w_c[NIBBLE_W];
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-word add/subtract engine: one nibble per clock, LSB nibble first,
// with carry rolled between cycles and full-width result plus flags.
module serial_nibble_adder
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  op_b,
  input  logic                         sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  result,
  output logic                         carry_out,
  output logic                         overflow
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_result;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_carry_out;
  logic             r_overflow;

  logic [W-1:0]          w_b_eff;
  logic [NIBBLE_W-1:0]   w_sum;
  logic                  w_cout;
  logic [W-1:0]          w_result_next;

  // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
  assign w_b_eff = sub ? ~op_b : op_b;

  nibble_adder_cin u_nibble_adder (
    .a    (r_a[NIBBLE_W-1:0]),
    .b    (r_b[NIBBLE_W-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Each new nibble enters at the top so the first one ends up in bits [3:0].
  generate
    if (NIBBLES == 1) begin : g_single
      assign w_result_next = w_sum;
    end else begin : g_multi
      assign w_result_next = {w_sum, r_result[W-1:NIBBLE_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= w_b_eff;
            r_carry <= sub;
            r_cnt   <= '0;
            r_a_msb <= op_a[W-1];
            r_b_msb <= w_b_eff[W-1];
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> NIBBLE_W;
          r_b      <= r_b >> NIBBLE_W;
          r_result <= w_result_next;
          r_carry  <= w_cout;
          if (r_cnt == LAST) begin
            r_cnt       <= '0;
            r_carry_out <= w_cout;
            // The last nibble's top bit is the result sign bit.
            r_overflow  <= (r_a_msb == r_b_msb) && (w_sum[NIBBLE_W-1] != r_a_msb);
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
